fp32_stream_argmax: RTL
=======================

# fp32_stream_argmax

Streaming IEEE 754 single-precision max/argmax unit for the softmax path. Consumes frames of N fp32 scores over a valid/ready stream and returns the frame maximum together with the index of its first occurrence. Uses a correct total-order float compare, handles negative inputs, and keeps throughput at one element per cycle with no bubble between frames. Sits in front of the softmax exponent stage, which subtracts the max, and also supplies the final MNIST class decision.

## Interface
- `N`, 10: elements per frame, at least 1.
- `IDX_W`, `(N>1)?$clog2(N):1`: width of the index and element counter.

- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset. One clock; reset is synchronous and active-low.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  the block can accept an element; combinational, equal to `!out_valid | out_ready`.
- `in_data`  in  32  fp32 element.
- `in_last`  in  1  upstream end-of-frame marker; used only for checking.
- `out_valid`  out  1  result is valid; held until consumed.
- `out_ready`  in  1  downstream accepts the result.
- `out_max`  out  32  frame maximum as a raw fp32 bit pattern.
- `out_idx`  out  IDX_W  index (0..N-1) of the first element equal to the maximum.
- `out_err`  out  1  `in_last` did not coincide with element N-1 somewhere in this frame.

## Operation
- An element is accepted when `in_valid & in_ready`.
- The element counter `cnt` runs 0..N-1 and wraps to 0 after N-1.
- Compare key, unsigned: `key = x[31] ? ~x : x ^ 32'h80000000`.
  - This gives -inf < negatives < -0 < +0 < positives < +inf.
  - +0 is greater than -0.
- Accumulator states:
  - S_FIRST (`cnt==0`): the accepted element loads `acc_max`, `acc_key` and `acc_idx=0`, and clears `acc_err`.
  - S_ACC (`cnt>0`): replace the accumulator only if `key(in) > acc_key`, strictly greater. Ties keep the earlier index.
- `acc_err` sets when either of these holds:
  - `in_last=1` on an element with `cnt != N-1`;
  - `in_last=0` on element N-1.
- On acceptance of element N-1:
  - The final compare result (including that element) loads `out_max`, `out_idx` and `out_err`.
  - `out_valid` sets to 1.
  - `cnt` returns to 0, i.e. S_FIRST.
- The frame length is always N. `in_last` never shortens or extends a frame.
- `out_valid` clears on `out_valid & out_ready`, unless a new frame completes in the same cycle. In that case `out_valid` stays 1 and the output registers take the new result.
- `in_data` is not checked for denormals; they compare correctly through the key.

## Timing
- Reset (`rst_n=0` at a clock edge):
  - `out_valid=0`, `out_max=32'h0`, `out_idx=0`, `out_err=0`;
  - `cnt=0`, accumulator cleared;
  - `in_ready=1` after reset.
- Reset mid-frame discards the partial frame and any pending result. The next accepted element is element 0.
- Latency: `out_valid` rises on the clock edge that accepts element N-1, so it is visible the cycle after that element's handshake.
- Throughput: 1 element/cycle.
- Back-to-back frames have zero bubble while `out_ready=1`.
- Backpressure:
  - With `out_valid=1` and `out_ready=0`, `in_ready=0`.
  - The partial frame already in the accumulator is preserved.
  - Outputs stay stable until consumed.
- `in_valid` high with `in_ready` low is a no-op. Upstream must hold its data.
- N=1: every accepted element is a complete frame, with `out_idx=0` and `out_err=!in_last`.

## Configuration
- `FP_ARGMAX_NAN_EN` defined:
  - An input with exponent 0xFF and nonzero mantissa is a NaN.
  - The first NaN in a frame wins: a sticky flag is set and `acc_idx` takes that NaN's index.
  - Later elements in the frame do not replace it.
  - Result `out_max=32'h7FC00000` (canonical qNaN).
- `FP_ARGMAX_NAN_EN` undefined:
  - There is no NaN detection; NaNs order by raw key.
  - A positive NaN beats +inf, a negative NaN loses to -inf.
  - `out_max` is the raw input bit pattern.

## Test plan
- N=10, frame {1.0, -2.0, 3.5, 0.5, 0, 0, 0, 0, 0, 0}, `in_last` on element 9, `out_ready=1`:
  - `out_max=32'h40600000`, `out_idx=2`, `out_err=0`;
  - `out_valid` one cycle after element 9.
- All-negative frame {-5, -1, -3, -8, …, -9} -> `out_max=32'hBF800000`, `out_idx=1`.
- Ties and signed zero:
  - {-0, +0, -1, …} -> `out_max=32'h00000000`, `out_idx=1`.
  - 2.0 at index 3 and index 7, largest in frame -> `out_idx=3`.
- Backpressure and throughput:
  - Two frames streamed continuously; hold `out_ready=0` for 5 cycles after the first result.
  - `in_ready=0` for those cycles and the second frame resumes without data loss.
  - With `out_ready=1` throughout, 20 elements complete in 20 cycles.
- Marker check and reset:
  - `in_last` at element 4 -> `out_err=1`; the max is still computed over all 10 elements.
  - `rst_n=0` after element 6 of a frame -> the next 10 elements form a clean frame.
- NaN input `32'h7FC00001` at index 5, with 10.0 at index 8:
  - With the macro -> `out_max=32'h7FC00000`, `out_idx=5`.
  - Without the macro -> `out_max=32'h7FC00001`, `out_idx=5`.

Source files
------------

// File: rtl/fp32_stream_argmax.sv
// Streaming fp32 max/argmax over fixed N-element frames, one element per cycle.
// Define FP_ARGMAX_NAN_EN to make the first NaN in a frame win (reported as canonical qNaN).
module fp32_stream_argmax #(
    parameter int unsigned N     = 10,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_max,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_err
);

    typedef enum logic {S_FIRST, S_ACC} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [31:0]      QNAN     = 32'h7FC0_0000;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] cnt, cnt_nxt;

    logic [31:0]      acc_max, acc_key;
    logic [IDX_W-1:0] acc_idx;
    logic             acc_err;

    logic [31:0]      new_max, new_key, res_max, in_key;
    logic [IDX_W-1:0] new_idx;
    logic             new_err;
    logic             accept, at_last, marker_bad, frame_done;

`ifdef FP_ARGMAX_NAN_EN
    logic             acc_nan, new_nan, in_nan;
`endif

    // Unsigned key giving a total order: -inf < negatives < -0 < +0 < positives < +inf.
    function automatic logic [31:0] fp_key(input logic [31:0] x);
        return x[31] ? ~x : (x ^ 32'h8000_0000);
    endfunction

    assign in_ready = !out_valid | out_ready;

    always_comb begin
        accept     = in_valid & in_ready;
        at_last    = (cnt == LAST_IDX);
        marker_bad = in_last ^ at_last;
        frame_done = accept & at_last;
        in_key     = fp_key(in_data);

        new_max = acc_max;
        new_key = acc_key;
        new_idx = acc_idx;
        new_err = acc_err | marker_bad;
`ifdef FP_ARGMAX_NAN_EN
        in_nan  = (&in_data[30:23]) & (|in_data[22:0]);
        new_nan = acc_nan;
`endif

        if (state == S_FIRST) begin
            new_max = in_data;
            new_key = in_key;
            new_idx = '0;
            new_err = marker_bad;
`ifdef FP_ARGMAX_NAN_EN
            new_nan = in_nan;
`endif
        end else begin
`ifdef FP_ARGMAX_NAN_EN
            // A latched NaN is sticky; otherwise a new NaN or a strictly larger key wins.
            if (!acc_nan && (in_nan || (in_key > acc_key))) begin
                new_max = in_data;
                new_key = in_key;
                new_idx = cnt;
                new_nan = in_nan;
            end
`else
            if (in_key > acc_key) begin
                new_max = in_data;
                new_key = in_key;
                new_idx = cnt;
            end
`endif
        end

        res_max = new_max;
`ifdef FP_ARGMAX_NAN_EN
        if (new_nan) begin
            res_max = QNAN;
        end
`endif

        state_nxt = state;
        cnt_nxt   = cnt;
        if (accept) begin
            if (at_last) begin
                cnt_nxt   = '0;
                state_nxt = S_FIRST;
            end else begin
                cnt_nxt   = cnt + 1'b1;
                state_nxt = S_ACC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_FIRST;
            cnt       <= '0;
            acc_max   <= '0;
            acc_key   <= '0;
            acc_idx   <= '0;
            acc_err   <= 1'b0;
`ifdef FP_ARGMAX_NAN_EN
            acc_nan   <= 1'b0;
`endif
            out_valid <= 1'b0;
            out_max   <= '0;
            out_idx   <= '0;
            out_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                acc_max <= new_max;
                acc_key <= new_key;
                acc_idx <= new_idx;
                acc_err <= new_err;
`ifdef FP_ARGMAX_NAN_EN
                acc_nan <= new_nan;
`endif
            end
            if (frame_done) begin
                out_valid <= 1'b1;
                out_max   <= res_max;
                out_idx   <= new_idx;
                out_err   <= new_err;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
